// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load extraction,
// writeback select and retired-instruction counter.
package mem_wb_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_RSV  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc4;
    } mem_wb_t;

endpackage

module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic                 regwrite_in,
    input  logic [4:0]           rd_in,
    input  logic [1:0]           wb_sel_in,
    input  logic [2:0]           funct3_in,
    input  logic [31:0]          alu_result_in,
    input  logic [31:0]          load_word_in,
    input  logic [31:0]          pc_plus4_in,
    output logic                 writeEn,
    output logic [4:0]           Waddr,
    output logic [31:0]          writeData,
    output logic                 load_misalign,
    output logic [CNT_WIDTH-1:0] instret
);

    mem_wb_t d;
    mem_wb_t q;

    logic [1:0]  off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    logic is_half;
    logic is_word;
    logic sel_alu;
    logic sel_ld;
    logic sel_pc;
    logic sel_rsv;
    logic retire;

    assign d.valid    = valid_in;
    assign d.regwrite = regwrite_in;
    assign d.rd       = rd_in;
    assign d.wb_sel   = wb_sel_in;
    assign d.funct3   = funct3_in;
    assign d.alu      = alu_result_in;
    assign d.ld       = load_word_in;
    assign d.pc4      = pc_plus4_in;

    // Stage register: flush beats stall, stall holds, else capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

    assign off     = q.alu[1:0];
    assign sel_alu = (q.wb_sel == WB_ALU);
    assign sel_ld  = (q.wb_sel == WB_LOAD);
    assign sel_pc  = (q.wb_sel == WB_PC4);
    assign sel_rsv = (q.wb_sel == WB_RSV);

    assign is_half = (q.funct3 == F3_LH)
                   | (q.funct3 == F3_LHU);
    assign is_word = (q.funct3 == F3_LW);

    // Pick the addressed byte and halfword out of the loaded word.
    always_comb begin
        byte_v = 8'h00;
        unique case (off)
            2'd0: byte_v = q.ld[7:0];
            2'd1: byte_v = q.ld[15:8];
            2'd2: byte_v = q.ld[23:16];
            2'd3: byte_v = q.ld[31:24];
        endcase
        half_v = off[1] ? q.ld[31:16] : q.ld[15:0];
    end

    // Sign/zero extend by load type; unknown types yield zero.
    always_comb begin
        load_v = 32'h0;
        case (q.funct3)
            F3_LB:  load_v = {{24{byte_v[7]}}, byte_v};
            F3_LBU: load_v = {24'h0, byte_v};
            F3_LH:  load_v = {{16{half_v[15]}}, half_v};
            F3_LHU: load_v = {16'h0, half_v};
            F3_LW:  load_v = q.ld;
            default: load_v = 32'h0;
        endcase
    end

    assign load_misalign = q.valid & sel_ld
                         & ((is_half & off[0])
                         | (is_word & (off != 2'd0)));

    // Writeback source select.
    always_comb begin
        writeData = 32'h0;
        unique case (1'b1)
            sel_alu: writeData = q.alu;
            sel_ld:  writeData = load_v;
            sel_pc:  writeData = q.pc4;
            sel_rsv: writeData = 32'h0;
            default: writeData = 32'h0;
        endcase
    end

    assign writeEn = q.valid & q.regwrite
                   & (q.rd != 5'd0)
                   & ~load_misalign
                   & ~sel_rsv;

    assign Waddr = q.rd;

    // The held instruction retires when it leaves the stage.
    assign retire = q.valid & ~load_misalign
                  & (~stall | flush);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage with
// hand-computed expected values.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic        regwrite_in;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in;
    logic [31:0] load_word_in;
    logic [31:0] pc_plus4_in;
    logic        writeEn;
    logic [4:0]  Waddr;
    logic [31:0] writeData;
    logic        load_misalign;
    logic [3:0]  instret;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.CNT_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .valid_in      (valid_in),
        .regwrite_in   (regwrite_in),
        .rd_in         (rd_in),
        .wb_sel_in     (wb_sel_in),
        .funct3_in     (funct3_in),
        .alu_result_in (alu_result_in),
        .load_word_in  (load_word_in),
        .pc_plus4_in   (pc_plus4_in),
        .writeEn       (writeEn),
        .Waddr         (Waddr),
        .writeData     (writeData),
        .load_misalign (load_misalign),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v,
                         input logic rw,
                         input logic [4:0] rd,
                         input logic [1:0] wb,
                         input logic [2:0] f3,
                         input logic [31:0] alu,
                         input logic [31:0] ld,
                         input logic [31:0] pc4);
        valid_in      = v;
        regwrite_in   = rw;
        rd_in         = rd;
        wb_sel_in     = wb;
        funct3_in     = f3;
        alu_result_in = alu;
        load_word_in  = ld;
        pc_plus4_in   = pc4;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1, 1, 5'd9, 2'b00, 3'b000,
              32'hDEAD, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_we",    32'(writeEn), 32'h0);
        chk("rst_waddr", 32'(Waddr), 32'h0);
        chk("rst_wdata", writeData, 32'h0);
        chk("rst_mis",   32'(load_misalign), 32'h0);
        chk("rst_cnt",   32'(instret), 32'h0);

        rst = 1'b0;
        drive(1, 1, 5'd5, 2'b00, 3'b000,
              32'h1234, 32'h0, 32'h0);
        tick();
        chk("alu_we",    32'(writeEn), 32'h1);
        chk("alu_waddr", 32'(Waddr), 32'h5);
        chk("alu_wdata", writeData, 32'h1234);
        chk("alu_cnt0",  32'(instret), 32'h0);
        drive(0, 0, 5'd0, 2'b00, 3'b000,
              32'h0, 32'h0, 32'h0);
        tick();
        chk("alu_cnt1",  32'(instret), 32'h1);
        chk("bub_we",    32'(writeEn), 32'h0);

        drive(1, 1, 5'd3, 2'b01, 3'b000,
              32'h103, 32'h80FF7F01, 32'h0);
        tick();
        chk("lb_wdata",  writeData, 32'hFFFFFF80);
        chk("lb_we",     32'(writeEn), 32'h1);
        chk("lb_cnt",    32'(instret), 32'h1);
        funct3_in = 3'b100;
        tick();
        chk("lbu_wdata", writeData, 32'h00000080);
        chk("lbu_cnt",   32'(instret), 32'h2);
        funct3_in = 3'b001;
        alu_result_in = 32'h102;
        tick();
        chk("lh_wdata",  writeData, 32'hFFFF80FF);
        chk("lh_mis",    32'(load_misalign), 32'h0);
        funct3_in = 3'b101;
        alu_result_in = 32'h100;
        tick();
        chk("lhu_wdata", writeData, 32'h00007F01);
        funct3_in = 3'b010;
        tick();
        chk("lw_wdata",  writeData, 32'h80FF7F01);
        chk("lw_cnt",    32'(instret), 32'h5);
        funct3_in = 3'b000;
        alu_result_in = 32'h101;
        tick();
        chk("lb1_wdata", writeData, 32'h0000007F);

        drive(1, 1, 5'd7, 2'b01, 3'b010,
              32'h102, 32'h80FF7F01, 32'h0);
        tick();
        chk("mis_flag",  32'(load_misalign), 32'h1);
        chk("mis_we",    32'(writeEn), 32'h0);
        chk("mis_waddr", 32'(Waddr), 32'h7);
        chk("mis_cnt0",  32'(instret), 32'h7);
        drive(0, 0, 5'd0, 2'b00, 3'b000,
              32'h0, 32'h0, 32'h0);
        tick();
        chk("mis_cnt1",  32'(instret), 32'h7);
        chk("mis_clr",   32'(load_misalign), 32'h0);

        drive(1, 1, 5'd0, 2'b10, 3'b000,
              32'h0, 32'h0, 32'h44);
        tick();
        chk("x0_we",     32'(writeEn), 32'h0);
        chk("x0_waddr",  32'(Waddr), 32'h0);
        chk("x0_wdata",  writeData, 32'h44);

        drive(1, 1, 5'd9, 2'b11, 3'b000,
              32'h55, 32'h0, 32'h44);
        tick();
        chk("rsv_we",    32'(writeEn), 32'h0);
        chk("rsv_wdata", writeData, 32'h0);
        chk("rsv_cnt",   32'(instret), 32'h8);

        drive(1, 1, 5'd4, 2'b01, 3'b011,
              32'h0, 32'h12345678, 32'h0);
        tick();
        chk("udf_wdata", writeData, 32'h0);
        chk("udf_we",    32'(writeEn), 32'h1);
        chk("udf_cnt",   32'(instret), 32'h9);

        drive(1, 1, 5'd10, 2'b00, 3'b000,
              32'hABCD, 32'h0, 32'h0);
        tick();
        chk("pre_stall", 32'(instret), 32'hA);
        stall = 1'b1;
        drive(1, 1, 5'd11, 2'b00, 3'b000,
              32'h5555, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_we",    32'(writeEn), 32'h1);
            chk("stl_waddr", 32'(Waddr), 32'hA);
            chk("stl_wdata", writeData, 32'hABCD);
            chk("stl_cnt",   32'(instret), 32'hA);
        end
        flush = 1'b1;
        tick();
        chk("sf_we",     32'(writeEn), 32'h0);
        chk("sf_cnt",    32'(instret), 32'hB);
        stall = 1'b0;
        tick();
        chk("fl_we",     32'(writeEn), 32'h0);
        chk("fl_cnt",    32'(instret), 32'hB);
        flush = 1'b0;

        drive(1, 1, 5'd12, 2'b00, 3'b000,
              32'h77, 32'h0, 32'h0);
        tick();
        chk("ar_pre_we", 32'(writeEn), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_we",     32'(writeEn), 32'h0);
        chk("ar_cnt",    32'(instret), 32'h0);
        chk("ar_wdata",  writeData, 32'h0);
        chk("ar_waddr",  32'(Waddr), 32'h0);
        @(negedge clk);
        chk("ar_hold",   32'(writeEn), 32'h0);
        rst = 1'b0;
        tick();
        chk("rel_we",    32'(writeEn), 32'h1);
        chk("rel_cnt",   32'(instret), 32'h0);
        for (int i = 0; i < 16; i++) tick();
        chk("wrap_cnt0", 32'(instret), 32'h0);
        tick();
        chk("wrap_cnt1", 32'(instret), 32'h1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  hold the stage register contents.
REQ-005 flush  input  1  replace the incoming instruction with a bubble.
REQ-006 valid_in  input  1  the MEM-stage instruction is valid.
REQ-007 regwrite_in  input  1  the instruction writes rd.
REQ-008 rd_in  input  5  destination register index.
REQ-009 wb_sel_in  input  2  writeback source: 00 ALU, 01 load, 10 PC+4; 11 is reserved.
REQ-010 funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 alu_result_in  input  32  ALU result; bits [1:0] are the load byte offset.
REQ-012 load_word_in  input  32  aligned 32-bit word read from data memory.
REQ-013 pc_plus4_in  input  32  link value.
REQ-014 writeEn  output  1  register-file write enable.
REQ-015 Waddr  output  5  register-file write index.
REQ-016 writeData  output  32  register-file write data.
REQ-017 load_misalign  output  1  the held instruction is a misaligned load.
REQ-018 instret  output  CNT_WIDTH  count of retired instructions.

Function
REQ-019 The stage register SHALL hold valid_q, regwrite_q, rd_q, wb_sel_q, funct3_q, alu_q, ld_q, pc4_q.
REQ-020 On each clock edge the stage register SHALL update by this priority: flush -> valid_q=0, other fields don't-care; else stall -> all fields held; else all fields capture the *_in inputs.
REQ-021 Simultaneous flush and stall SHALL resolve as flush.
REQ-022 Latency SHALL be exactly one cycle: an instruction captured at edge N drives writeEn, Waddr and writeData combinationally from edge N until the next update.
REQ-023 Load extraction SHALL use offset = alu_q[1:0]:
- LB/LBU: byte ld_q[8*offset+7 : 8*offset], sign-extended for LB and zero-extended for LBU.
- LH/LHU: half ld_q[16*offset[1]+15 : 16*offset[1]], sign-extended for LH and zero-extended for LHU.
- LW: ld_q.
REQ-024 load_misalign SHALL be 1 iff valid_q=1, wb_sel_q=01, and either (LH/LHU with offset[0]=1) or (LW with offset!=0).
REQ-025 writeData SHALL be selected by wb_sel_q: 00 -> alu_q; 01 -> the extracted load value; 10 -> pc4_q; 11 -> 0.
REQ-026 An undefined funct3 with wb_sel_q=01 SHALL produce writeData=0.
REQ-027 writeEn SHALL equal valid_q & regwrite_q & (rd_q!=0) & !load_misalign & (wb_sel_q!=11).
REQ-028 Waddr SHALL always equal rd_q.
REQ-029 While stalled, writeEn SHALL remain asserted if its conditions hold; the repeated identical write is permitted.
REQ-030 instret SHALL increment by 1 on each edge where valid_q=1, load_misalign=0, and (stall=0 or flush=1).
REQ-031 instret SHALL wrap modulo 2^CNT_WIDTH.

Reset
REQ-032 While rst=1, the stage SHALL asynchronously force valid_q=0, instret=0, and all other stage fields to 0, giving writeEn=0, Waddr=0, writeData=0 and load_misalign=0.
REQ-033 Deassertion of rst SHALL take effect at the next rising edge, with no capture on the edge where rst is high.
REQ-034 Asserting rst mid-stall or mid-flush SHALL override both.

Verification
REQ-035 ALU write: valid_in=1, regwrite=1, rd=5, wb_sel=00, alu=0x1234 -> after 1 edge writeEn=1, Waddr=5, writeData=0x1234, and instret increments on the following edge.
REQ-036 LB sign extension: load_word=0x80FF7F01, alu=0x103, LB -> writeData=0xFFFFFF80; same with LBU -> 0x00000080; LH with alu=0x102 -> 0xFFFF80FF.
REQ-037 Misalign: LW with alu=0x102, rd=7 -> load_misalign=1, writeEn=0, instret unchanged.
REQ-038 x0 write: rd=0, regwrite=1, wb_sel=10, pc_plus4=0x44 -> writeEn=0 and Waddr=0.
REQ-039 Stall/flush: stall=1 for 3 cycles holds the outputs and instret; stall=1 with flush=1 -> valid_q=0 on the next edge and instret incremented once for the departing instruction.
REQ-040 Async reset: assert rst between edges while writeEn=1 -> writeEn=0 and instret=0 immediately, without waiting for clk.
